inst_debounce: RTL

- Parametrised, multi-channel successor to the instrument strum/foot debouncer.
- Synchronises N_CH raw instrument contact inputs into the clk domain and filters each channel with its own debounce threshold.
- Outputs a clean level per channel, plus one-cycle rise and fall strobes.
- Sits between the instrument pin inputs and the instrument controller logic, which consumes the levels and strobes.

---
 rtl/inst_pkg.sv | 19 +
 rtl/debounce_chan.sv | 79 +++++++
 rtl/inst_debounce.sv | 50 +++++
 3 files changed

// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - shared constants and helpers for the instrument contact debouncer
// Contents: channel index constants, default thresholds and the threshold clamp helper.
package inst_pkg;

    localparam int CH_STRUM_G = 0;
    localparam int CH_STRUM_B = 1;
    localparam int CH_FOOT    = 2;

    // 10 ms at the nominal 50 MHz clock
    localparam int unsigned DEBOUNCE_10MS = 500000;
    localparam int unsigned DEBOUNCE_MIN  = 2;

    // A threshold of zero would mean "change with no settle time"; the
    // counter compares against T-1, so zero is clamped up to one.
    function automatic int unsigned eff_threshold(input int unsigned t);
        return (t == 0) ? 1 : t;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, settle counter, edge strobes
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : raw asynchronous contact input
//   en         : filter enable (counter and level freeze when low)
//   level      : debounced level
//   rise, fall : one-cycle strobes on level 0->1 / 1->0
//   busy       : a change is pending (counter non-zero)
module debounce_chan
    import inst_pkg::*;
#(
    parameter int          CNT_W       = 20,
    parameter int unsigned T           = 2,
    parameter logic        RESET_VAL   = 1'b0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic en,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned      T_EFF = eff_threshold(T);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(T_EFF - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_chan: SYNC_STAGES must be at least 2");
    end
    if (64'(T) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("debounce_chan: threshold does not fit in CNT_W bits");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s    = sync[SYNC_STAGES-1];
    assign busy = (cnt != '0);

    // The synchroniser runs regardless of en so that s is current on re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    // Any cycle where s agrees with level discards the partial count, so only
    // T consecutive disagreeing samples move the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= RESET_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                if (s == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level <= s;
                    cnt   <= '0;
                    rise  <= s;
                    fall  <= ~s;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/inst_debounce.sv
// rtl/inst_debounce.sv - multi-channel instrument contact debouncer
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   inst       : raw contact inputs, one bit per channel
//   en         : filter enable shared by all channels
//   level      : debounced levels
//   rise, fall : one-cycle strobes per channel
//   busy       : per-channel change pending
module inst_debounce
    import inst_pkg::*;
#(
    parameter int                     N_CH        = 3,
    parameter int                     CNT_W       = 20,
    parameter logic [N_CH*CNT_W-1:0]  DEBOUNCE    = {CNT_W'(DEBOUNCE_10MS),
                                                     CNT_W'(DEBOUNCE_MIN),
                                                     CNT_W'(DEBOUNCE_MIN)},
    parameter logic [N_CH-1:0]        RESET_VAL   = '0,
    parameter int                     SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] inst,
    input  logic            en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        localparam int unsigned T_I = 32'(DEBOUNCE[i*CNT_W +: CNT_W]);

        debounce_chan #(
            .CNT_W       (CNT_W),
            .T           (T_I),
            .RESET_VAL   (RESET_VAL[i]),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (inst[i]),
            .en    (en),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .busy  (busy[i])
        );
    end

endmodule
